// File: rtl/i2s_pkg.sv
// Shared constants, FSM state type and elaboration helpers for the I2S/TDM frame generator.
package i2s_pkg;

  localparam logic [1:0] FMT_I2S = 2'd0;
  localparam logic [1:0] FMT_LJ  = 2'd1;
  localparam logic [1:0] FMT_DSP = 2'd2;

  localparam int unsigned SLOT_BITS_16 = 16;
  localparam int unsigned SLOT_BITS_24 = 24;
  localparam int unsigned SLOT_BITS_32 = 32;

  typedef enum logic {StIdle, StRun} state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic bit slot_bits_legal(input int unsigned n);
    return (n == SLOT_BITS_16) || (n == SLOT_BITS_24) || (n == SLOT_BITS_32);
  endfunction

  // Reserved encoding 3 behaves as I2S.
  function automatic logic [1:0] fmt_sanitize(input logic [1:0] f);
    return (f == 2'd3) ? FMT_I2S : f;
  endfunction

endpackage

// File: rtl/i2s_bck_divider.sv
// BCK generator: half-period counter, registered bck and one-cycle rise/fall strobes.
module i2s_bck_divider #(
  parameter int unsigned DIV_W = 4
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             restart,
  input  logic [DIV_W-1:0] half_div,
  output logic             bck,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             fall_next
);

  logic [DIV_W-1:0] hc_q, hc_d;
  logic             bck_q, bck_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             at_top;

  assign at_top    = (hc_q >= half_div);
  // Next cycle brings a falling edge; the frame logic advances on it.
  assign fall_next = at_top & bck_q;

  always_comb begin
    hc_d   = hc_q;
    bck_d  = bck_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (clear) begin
      hc_d  = '0;
      bck_d = 1'b0;
    end else if (restart) begin
      hc_d   = '0;
      bck_d  = 1'b0;
      fall_d = 1'b1;
    end else if (at_top) begin
      hc_d   = '0;
      bck_d  = ~bck_q;
      rise_d = ~bck_q;
      fall_d = bck_q;
    end else begin
      hc_d = hc_q + DIV_W'(1);
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q   <= '0;
      bck_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      hc_q   <= hc_d;
      bck_q  <= bck_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bck      = bck_q;
  assign rise_stb = rise_q;
  assign fall_stb = fall_q;

endmodule

// File: rtl/i2s_frame_gen.sv
// I2S/TDM master timing generator in the mclk domain: frame FSM, bit/slot counters,
// lrck encoder and frame-aligned configuration staging around the BCK divider.
module i2s_frame_gen
  import i2s_pkg::*;
#(
  parameter int unsigned SLOTS            = 2,
  parameter int unsigned SLOT_BITS        = 32,
  parameter int unsigned DIV_W            = 4,
  parameter int unsigned DEFAULT_HALF_DIV = 1,
  parameter int unsigned DEFAULT_FMT      = 0
) (
  input  logic                         mclk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [DIV_W-1:0]             cfg_half_div,
  input  logic [1:0]                   cfg_fmt,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  output logic                         bck,
  output logic                         lrck,
  output logic                         bck_rise_stb,
  output logic                         bck_fall_stb,
  output logic                         frame_start,
  output logic [idx_w(SLOTS)-1:0]      slot_idx,
  output logic [idx_w(SLOT_BITS)-1:0]  bit_idx,
  output logic                         running
);

  localparam int unsigned SLOT_W = idx_w(SLOTS);
  localparam int unsigned BIT_W  = idx_w(SLOT_BITS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(SLOT_BITS - 1);

  if (!slot_bits_legal(SLOT_BITS)) begin : g_bad_slot_bits
    $error("SLOT_BITS must be 16, 24 or 32");
  end
  if (SLOTS < 2 || (SLOTS & (SLOTS - 1)) != 0) begin : g_bad_slots
    $error("SLOTS must be a power of two and at least 2");
  end
  if (DIV_W < 1 || DEFAULT_HALF_DIV >= (1 << DIV_W)) begin : g_bad_div
    $error("DEFAULT_HALF_DIV does not fit in DIV_W bits");
  end
  if (DEFAULT_FMT > 3) begin : g_bad_fmt
    $error("DEFAULT_FMT must be 0..3");
  end

  // Upper half of the slot range is the right channel since SLOTS is a power of two.
  function automatic logic lrck_enc(input logic [1:0] fmt, input logic [SLOT_W-1:0] slot,
                                    input logic [BIT_W-1:0] bpos);
    logic [SLOT_W-1:0] slot_nx;
    slot_nx = (bpos == LAST_BIT) ? slot + SLOT_W'(1) : slot;
    case (fmt)
      FMT_LJ:  return ~slot[SLOT_W-1];
      FMT_DSP: return (slot == LAST_SLOT) && (bpos == LAST_BIT);
      default: return slot_nx[SLOT_W-1];
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              lrck_q, lrck_d;
  logic              fs_q, fs_d;
  logic [DIV_W-1:0]  half_q, half_d;
  logic [1:0]        fmt_q, fmt_d;
  logic              pend_q, pend_d;
  logic [DIV_W-1:0]  pend_half_q, pend_half_d;
  logic [1:0]        pend_fmt_q, pend_fmt_d;
  logic              ready_q, ready_d;
  logic              accept, wrap, fall_next;

  assign accept = cfg_valid && ready_q;
  assign wrap   = (slot_q == LAST_SLOT) && (bit_q == LAST_BIT);

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    bit_d       = bit_q;
    lrck_d      = lrck_q;
    fs_d        = 1'b0;
    half_d      = half_q;
    fmt_d       = fmt_q;
    pend_d      = pend_q;
    pend_half_d = pend_half_q;
    pend_fmt_d  = pend_fmt_q;
    ready_d     = ready_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          half_d = cfg_half_div;
          fmt_d  = fmt_sanitize(cfg_fmt);
        end
        if (en) begin
          state_d = StRun;
          slot_d  = '0;
          bit_d   = '0;
          fs_d    = 1'b1;
          lrck_d  = lrck_enc(fmt_d, '0, '0);
        end
      end
      StRun: begin
        if (accept) begin
          pend_d      = 1'b1;
          pend_half_d = cfg_half_div;
          pend_fmt_d  = fmt_sanitize(cfg_fmt);
          ready_d     = 1'b0;
        end
        if (fall_next) begin
          if (bit_q == LAST_BIT) begin
            bit_d  = '0;
            slot_d = slot_q + SLOT_W'(1);
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
          if (wrap) begin
            if (pend_q) begin
              half_d = pend_half_q;
              fmt_d  = pend_fmt_q;
              pend_d = 1'b0;
            end
            if (!en) begin
              state_d = StIdle;
              lrck_d  = 1'b0;
              // Nothing left to wait for once idle, so a same-cycle accept lands now.
              if (accept) begin
                half_d = cfg_half_div;
                fmt_d  = fmt_sanitize(cfg_fmt);
                pend_d = 1'b0;
              end
            end else begin
              fs_d   = 1'b1;
              lrck_d = lrck_enc(fmt_d, '0, '0);
            end
          end else begin
            lrck_d = lrck_enc(fmt_q, slot_d, bit_d);
          end
        end
      end
    endcase
    // Re-open the handshake one cycle after the pending configuration has been consumed.
    if (!accept && !pend_q && !ready_q) begin
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      slot_q      <= '0;
      bit_q       <= '0;
      lrck_q      <= 1'b0;
      fs_q        <= 1'b0;
      half_q      <= DIV_W'(DEFAULT_HALF_DIV);
      fmt_q       <= fmt_sanitize(2'(DEFAULT_FMT));
      pend_q      <= 1'b0;
      pend_half_q <= '0;
      pend_fmt_q  <= FMT_I2S;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      bit_q       <= bit_d;
      lrck_q      <= lrck_d;
      fs_q        <= fs_d;
      half_q      <= half_d;
      fmt_q       <= fmt_d;
      pend_q      <= pend_d;
      pend_half_q <= pend_half_d;
      pend_fmt_q  <= pend_fmt_d;
      ready_q     <= ready_d;
    end
  end

  i2s_bck_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .mclk      (mclk),
    .rst_n     (rst_n),
    .clear     (state_d == StIdle),
    .restart   ((state_q == StIdle) && (state_d == StRun)),
    .half_div  (half_q),
    .bck       (bck),
    .rise_stb  (bck_rise_stb),
    .fall_stb  (bck_fall_stb),
    .fall_next (fall_next)
  );

  assign cfg_ready   = ready_q;
  assign lrck        = lrck_q;
  assign frame_start = fs_q;
  assign slot_idx    = slot_q;
  assign bit_idx     = bit_q;
  assign running     = (state_q == StRun);

endmodule

// File: tb/tb_i2s_frame_gen.sv
// Scoreboard bench: each phase queues the expected per-bit view of upcoming frames and a
// monitor checks every bck_fall_stb against it; phase-specific checks run inline.
module tb_i2s_frame_gen;

  localparam int SB = 32;
  localparam int NB = 64;
  localparam int F_I2S = 0;
  localparam int F_LJ  = 1;
  localparam int F_DSP = 2;

  logic       mclk = 1'b0;
  logic       rst_n, en, cfg_valid;
  logic [3:0] cfg_half_div;
  logic [1:0] cfg_fmt;
  logic       cfg_ready, bck, lrck, bck_rise_stb, bck_fall_stb, frame_start, running;
  logic       slot_idx;
  logic [4:0] bit_idx;

  typedef struct {
    int   gap;
    int   b;
    logic fs;
    logic lr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_fall = 0;

  always #5 mclk = ~mclk;

  i2s_frame_gen #(
    .SLOTS            (2),
    .SLOT_BITS        (32),
    .DIV_W            (4),
    .DEFAULT_HALF_DIV (1),
    .DEFAULT_FMT      (0)
  ) dut (
    .mclk         (mclk),
    .rst_n        (rst_n),
    .en           (en),
    .cfg_half_div (cfg_half_div),
    .cfg_fmt      (cfg_fmt),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .bck          (bck),
    .lrck         (lrck),
    .bck_rise_stb (bck_rise_stb),
    .bck_fall_stb (bck_fall_stb),
    .frame_start  (frame_start),
    .slot_idx     (slot_idx),
    .bit_idx      (bit_idx),
    .running      (running)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // lrck for frame position b, written from the frame-level definition.
  function automatic logic exp_lrck(input int fmt, input int b);
    if (fmt == F_LJ)  return (b / SB) < 1;
    if (fmt == F_DSP) return b == NB - 1;
    return (((b + 1) % NB) / SB) >= 1;
  endfunction

  task automatic push_frame(input int fmt, input int first_gap, input int gap);
    exp_t e;
    for (int b = 0; b < NB; b++) begin
      e.gap = (b == 0) ? first_gap : gap;
      e.b   = b;
      e.fs  = (b == 0);
      e.lr  = exp_lrck(fmt, b);
      sb.push_back(e);
    end
  endtask

  always @(negedge mclk) begin
    exp_t e;
    cyc++;
    if (bck_rise_stb) chk("strobes exclusive", int'(bck_fall_stb), 0);
    if (frame_start) chk("frame_start on fall", int'(bck_fall_stb), 1);
    if (bck_fall_stb) begin
      chk("fall expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.gap > 0) chk("bck period", cyc - last_fall, e.gap);
        chk("bit position", int'(slot_idx) * SB + int'(bit_idx), e.b);
        chk("frame_start", int'(frame_start), int'(e.fs));
        chk("lrck", int'(lrck), int'(e.lr));
      end
      last_fall = cyc;
    end
  end

  task automatic wait_fall_b(input int b);
    bit found = 1'b0;
    for (int n = 0; n < 3000 && !found; n++) begin
      @(negedge mclk);
      found = bck_fall_stb && ((int'(slot_idx) * SB + int'(bit_idx)) == b);
    end
    chk("reach bit position", int'(found), 1);
  endtask

  task automatic wait_fs();
    bit found = 1'b0;
    for (int n = 0; n < 3000 && !found; n++) begin
      @(negedge mclk);
      found = frame_start;
    end
    chk("reach frame_start", int'(found), 1);
  endtask

  task automatic drain();
    bit empty = 1'b0;
    for (int n = 0; n < 3000 && !empty; n++) begin
      @(negedge mclk);
      empty = (sb.size() == 0);
    end
    chk("scoreboard drained", sb.size(), 0);
  endtask

  task automatic do_cfg(input logic [3:0] h, input logic [1:0] f);
    chk("cfg_ready before accept", int'(cfg_ready), 1);
    cfg_half_div = h;
    cfg_fmt      = f;
    cfg_valid    = 1'b1;
    @(negedge mclk);
    cfg_valid    = 1'b0;
    cfg_half_div = 4'd9;  // unhandshaken change must be ignored
    cfg_fmt      = 2'd1;
    chk("cfg_ready after accept", int'(cfg_ready), 0);
  endtask

  task automatic chk_idle_outputs(input string name);
    logic [10:0] v;
    v = {bck, lrck, bck_rise_stb, bck_fall_stb, frame_start, running, slot_idx, bit_idx};
    chk(name, int'(v), 0);
    chk({name, " cfg_ready"}, int'(cfg_ready), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: run did not reach its end, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int   cnt;
    logic p;
    rst_n        = 1'b0;
    en           = 1'b1;
    cfg_valid    = 1'b0;
    cfg_half_div = 4'd0;
    cfg_fmt      = 2'd0;
    repeat (3) @(negedge mclk);
    chk_idle_outputs("reset state");

    // Defaults from reset: I2S, H=1.
    push_frame(F_I2S, -1, 4);
    @(negedge mclk);
    rst_n = 1'b1;
    @(negedge mclk);
    chk("start fall+frame_start", int'(bck_fall_stb && frame_start && running), 1);
    @(negedge mclk);
    @(negedge mclk);
    chk("first bck rise", int'(bck_rise_stb && bck), 1);

    // H 1 -> 3 accepted at b=10, takes effect at the next frame.
    wait_fall_b(10);
    do_cfg(4'd3, 2'd0);
    push_frame(F_I2S, 4, 8);
    wait_fs();
    chk("cfg_ready low at boundary", int'(cfg_ready), 0);
    @(negedge mclk);
    chk("cfg_ready after boundary", int'(cfg_ready), 1);

    // Left-justified, back to H=1.
    wait_fall_b(3);
    do_cfg(4'd1, 2'd1);
    push_frame(F_LJ, 8, 4);
    wait_fs();

    // DSP pulse format, then stop mid-frame.
    wait_fall_b(20);
    do_cfg(4'd1, 2'd2);
    push_frame(F_DSP, 4, 4);
    wait_fs();
    wait_fall_b(5);
    en = 1'b0;
    drain();
    repeat (4) @(negedge mclk);
    chk_idle_outputs("after stop");
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge mclk);
      cnt += int'(bck_rise_stb) + int'(bck_fall_stb) + int'(frame_start) + int'(running);
    end
    chk("idle activity", cnt, 0);

    // Restart keeps the DSP configuration; then switch to H=0 I2S.
    push_frame(F_DSP, -1, 4);
    en = 1'b1;
    @(negedge mclk);
    chk("restart frame_start", int'(frame_start && running), 1);
    wait_fall_b(5);
    do_cfg(4'd0, 2'd3);  // reserved format acts as I2S
    push_frame(F_I2S, 4, 2);
    wait_fs();
    wait_fall_b(3);
    for (int i = 0; i < 6; i++) begin
      p = bck;
      @(negedge mclk);
      chk("bck toggles at H=0", int'(bck), int'(!p));
    end

    // Asynchronous reset mid-frame restores defaults.
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async reset");
    sb.delete();
    push_frame(F_I2S, -1, 4);
    repeat (2) @(negedge mclk);
    rst_n = 1'b1;
    drain();
    chk("running after reset", int'(running), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_frame_gen.md
# i2s_frame_gen

Parametrised I2S/TDM master timing generator running entirely in the `mclk` domain. It produces BCK and LRCK/frame-sync as registered outputs, with no derived-clock flops, and supports run-time BCK ratio and serial format. It also issues per-bit strobes and slot/bit indices for the serialiser and deserialiser that sit beside it. It drives the PCM1808 ADC front end and any future TDM codecs, using the MCLK produced by the clock wizard.

## Interface
- `SLOTS`, 2: slots per frame; a power of two, ≥2.
- `SLOT_BITS`, 32: BCK periods per slot; one of 16, 24 or 32.
- `DIV_W`, 4: width of the BCK half-period divider.
- `DEFAULT_HALF_DIV`, 1: reset value of the active half-divider, giving BCK = mclk/4.
- `DEFAULT_FMT`, 0: reset value of the active format (I2S).

Ports:
- `mclk` in 1: master clock, 12.288 MHz nominal.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: run request.
- `cfg_half_div` in DIV_W: BCK half-period minus one, in mclk cycles.
- `cfg_fmt` in 2: 0 = I2S, 1 = left-justified, 2 = DSP/TDM pulse; 3 is reserved and treated as 0.
- `cfg_valid` in 1: new configuration offered.
- `cfg_ready` out 1: configuration can be accepted.
- `bck` out 1: bit clock.
- `lrck` out 1: word select / frame sync.
- `bck_rise_stb` out 1: 1-cycle pulse in the cycle `bck` goes high; receivers sample here.
- `bck_fall_stb` out 1: 1-cycle pulse in the cycle `bck` goes low; transmitters shift here.
- `frame_start` out 1: coincides with the `bck_fall_stb` that begins bit 0 of slot 0.
- `slot_idx` out clog2(SLOTS): current slot.
- `bit_idx` out clog2(SLOT_BITS): current bit in the slot, 0 = MSB.
- `running` out 1: high in RUN.

## Operation
- Terms:
  - H = active half-divider.
  - N = SLOTS·SLOT_BITS.
  - b = frame bit position = slot_idx·SLOT_BITS + bit_idx.
- States: IDLE and RUN.
- IDLE behaviour:
  - Outputs: `bck`=0, `lrck`=0, all strobes 0, indices 0, `running`=0.
- IDLE → RUN:
  - Condition: `en`=1.
  - Next cycle: `running`=1, b=0, `bck_fall_stb`=1, `frame_start`=1, `lrck` = value for b=0.
- Half-period counter hc (0..H):
  - Resets to 0 on every `bck` toggle.
  - `bck` toggles in the cycle after hc==H.
  - Each BCK level therefore lasts H+1 cycles, and BCK = mclk/(2(H+1)).
- Bit advance:
  - b advances on each falling edge, wrapping N−1 → 0.
  - The wrap edge is the frame boundary and asserts `frame_start`.
- `lrck` updates only in `bck_fall_stb` cycles. Its value for position b:
  - I2S: 1 iff slot((b+1) mod N) ≥ SLOTS/2. It changes one BCK before the MSB and is low for slot 0.
  - LJ: 1 iff slot(b) < SLOTS/2. It is high for slot 0, aligned with the MSB.
  - DSP: 1 iff b == N−1, i.e. a one-BCK pulse preceding slot 0's MSB.
- Stop:
  - `en`=0 is sampled at the frame boundary only, so the current frame always completes.
  - At a boundary with `en`=0, the block enters IDLE instead of starting bit 0.
  - `bck` stays 0, `lrck`→0, `running`→0, and no `frame_start` is issued.
- Configuration:
  - Handshake on `cfg_valid`&&`cfg_ready`; the accepted configuration is held as pending and `cfg_ready`→0.
  - The pending configuration becomes active at the next frame boundary and `cfg_ready`→1 the cycle after.
  - Accept in the same cycle as a boundary: applies at the following boundary.
  - In IDLE the configuration is applied the cycle after accept.
  - Pending at stop: applied on entering IDLE.
- Mid-frame changes to `cfg_*` without a handshake are ignored.
- Reset mid-operation:
  - Immediately IDLE, all outputs at IDLE values.
  - Active configuration returns to `DEFAULT_*`, pending is cleared, `cfg_ready`=1.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Start latency: `en` high at cycle t gives the first `bck_fall_stb` at t+1 and the first `bck` rise at t+1+(H+1).
- Frame length is 2N(H+1) mclk cycles.
  - Defaults: 256 cycles, BCK 3.072 MHz, LRCK 48 kHz.
- H=0 is legal: `bck` = mclk/2, and rise/fall strobes alternate every cycle.
- Strobes never assert in IDLE, and `bck_rise_stb` and `bck_fall_stb` are never both high.

## Structure
- `i2s_pkg`:
  - Format constants FMT_I2S=0, FMT_LJ=1, FMT_DSP=2.
  - Legal `SLOT_BITS` values.
  - clog2-derived index widths.
- Sub-module `i2s_bck_divider`:
  - Contains the hc counter, `bck` register and rise/fall strobes.
  - Inputs: enable and H.
- The top level owns the FSM, bit/slot counters, `lrck` encoder and configuration staging.
- The top level also contains static parameter checks.

## Test plan
- Defaults with `en`=1 from reset:
  - `bck` period 4 cycles; `lrck` period 256 cycles.
  - `lrck` rises at the `bck` fall where slot 0 bit 31 begins.
  - `frame_start` every 256 cycles.
- Formats:
  - LJ: `lrck` high for slot_idx 0, switching in the same cycle `bit_idx` becomes 0.
  - DSP with SLOTS=8, SLOT_BITS=32: `lrck` high exactly for b=255, i.e. a 1-BCK pulse every 256 BCK.
- Reconfiguration mid-frame: H=1→3 accepted at b=10.
  - Periods stay 4 cycles until the boundary, then become 8.
  - `cfg_ready` is low from accept until the cycle after the boundary.
- Stop: `en` drops at b=5.
  - The frame completes, then `running`=0, `bck`=0, `lrck`=0.
  - No further strobes and no `frame_start`.
  - `en` reasserted: `frame_start` the next cycle.
- H=0 edge case and async reset:
  - With H=0, `bck` toggles every cycle.
  - `rst_n` pulsed mid-frame: all outputs 0 immediately.
  - After release with `en`=1, the default 4-cycle BCK resumes from b=0.
